// File: rtl/imem_decompressor.sv
`timescale 1ns/1ps
// imem_decompressor
// Memory-side responder for the icache miss port. Each 32-bit instruction
// request becomes one fetch of a compressed word holding two halfwords. A
// halfword either indexes an on-chip dictionary or points at an
// uncompressed word in the escape region. A one-entry buffer keeps the last
// compressed word so that its partner instruction needs no memory access.
module imem_decompressor #(
    parameter int          DICT_ENTRIES = 256,
    parameter logic [31:0] CMEM_BASE    = 32'h0000_0000,
    parameter logic [31:0] ESC_BASE     = 32'h0004_0000,
    localparam int         DAW          = $clog2(DICT_ENTRIES)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mem_req_valid,
    output logic           mem_req_ready,
    input  logic [31:0]    mem_req_addr,
    output logic [31:0]    mem_req_rdata,
    output logic           cmem_valid,
    input  logic           cmem_ready,
    output logic [31:0]    cmem_addr,
    input  logic [31:0]    cmem_rdata,
    input  logic           dict_we,
    input  logic [DAW-1:0] dict_waddr,
    input  logic [31:0]    dict_wdata,
    output logic [31:0]    stat_buf_hits,
    output logic [31:0]    stat_escapes
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_C,
        S_DECODE,
        S_DICT,
        S_FETCH_E,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        bufValid_q, bufValid_d;
    logic [28:0] bufTag_q, bufTag_d;
    logic [31:0] bufData_q, bufData_d;
    logic [31:0] rdata_q, rdata_d;
    logic        cmemValid_q, cmemValid_d;
    logic [31:0] cmemAddr_q, cmemAddr_d;
    logic        ready_q, ready_d;
    logic [31:0] hits_q, hits_d;
    logic [31:0] escapes_q, escapes_d;

    logic [31:0] dictMem [DICT_ENTRIES];
    logic [31:0] dictRd_q;
    logic        dictRdEn;

    logic [15:0]    halfword;
    logic [DAW-1:0] dictIdx;
    logic [31:0]    cwordAddr;
    logic [31:0]    escAddr;
    logic           unusedAddrBits;

    // The byte offset inside an instruction word carries no information.
    assign unusedAddrBits = ^{mem_req_addr[1:0], addr_q[1:0]};

    // Halfword selection and the two memory addresses it can lead to.
    assign halfword  = addr_q[2] ? bufData_q[31:16] : bufData_q[15:0];
    assign dictIdx   = halfword[DAW-1:0];
    assign cwordAddr = (CMEM_BASE + {1'b0, mem_req_addr[31:3], 2'b00}) & 32'hFFFF_FFFC;
    assign escAddr   = (ESC_BASE + {15'b0, halfword[14:0], 2'b00}) & 32'hFFFF_FFFC;

    assign mem_req_ready = ready_q;
    assign mem_req_rdata = rdata_q;
    assign cmem_valid    = cmemValid_q;
    assign cmem_addr     = cmemAddr_q;
    assign stat_buf_hits = hits_q;
    assign stat_escapes  = escapes_q;

    // Dictionary RAM: synchronous read, never reset; a same-edge write to the read index yields the old word.
    always_ff @(posedge clk) begin
        if (dict_we) begin
            dictMem[dict_waddr] <= dict_wdata;
        end
        if (dictRdEn) begin
            dictRd_q <= dictMem[dictIdx];
        end
    end

    // State, buffer and registered outputs; reset drops any in-flight memory access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            bufValid_q  <= 1'b0;
            bufTag_q    <= '0;
            bufData_q   <= '0;
            rdata_q     <= '0;
            cmemValid_q <= 1'b0;
            cmemAddr_q  <= '0;
            ready_q     <= 1'b0;
            hits_q      <= '0;
            escapes_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bufValid_q  <= bufValid_d;
            bufTag_q    <= bufTag_d;
            bufData_q   <= bufData_d;
            rdata_q     <= rdata_d;
            cmemValid_q <= cmemValid_d;
            cmemAddr_q  <= cmemAddr_d;
            ready_q     <= ready_d;
            hits_q      <= hits_d;
            escapes_q   <= escapes_d;
        end
    end

    // Next state: outputs are computed for the state being entered so they appear registered.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        bufValid_d  = bufValid_q;
        bufTag_d    = bufTag_q;
        bufData_d   = bufData_q;
        rdata_d     = rdata_q;
        cmemValid_d = cmemValid_q;
        cmemAddr_d  = cmemAddr_q;
        ready_d     = 1'b0;
        hits_d      = hits_q;
        escapes_d   = escapes_q;
        dictRdEn    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req_valid) begin
                    addr_d = mem_req_addr;
                    if (bufValid_q && (bufTag_q == mem_req_addr[31:3])) begin
                        state_d = S_DECODE;
                        hits_d  = hits_q + 32'd1;
                    end else begin
                        state_d     = S_FETCH_C;
                        cmemValid_d = 1'b1;
                        cmemAddr_d  = cwordAddr;
                    end
                end
            end
            S_FETCH_C: begin
                if (cmem_ready) begin
                    bufData_d   = cmem_rdata;
                    bufTag_d    = addr_q[31:3];
                    bufValid_d  = 1'b1;
                    cmemValid_d = 1'b0;
                    state_d     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (halfword[15]) begin
                    state_d     = S_FETCH_E;
                    escapes_d   = escapes_q + 32'd1;
                    cmemValid_d = 1'b1;
                    cmemAddr_d  = escAddr;
                end else begin
                    state_d  = S_DICT;
                    dictRdEn = 1'b1;
                end
            end
            S_DICT: begin
                rdata_d = dictRd_q;
                ready_d = 1'b1;
                state_d = S_RESP;
            end
            S_FETCH_E: begin
                if (cmem_ready) begin
                    rdata_d     = cmem_rdata;
                    cmemValid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
